// File: rtl/uart_byte_tx_if.sv
// Byte-transmit handshake bundle: start/data from the producer,
// ready/serial line back from the transmitter.
interface uart_byte_tx_if;
    logic       txByteStart;
    logic [7:0] byteForTx;
    logic       txByteReady;
    logic       tx;

    modport master (
        output txByteStart,
        output byteForTx,
        input  txByteReady,
        input  tx
    );

    modport slave (
        input  txByteStart,
        input  byteForTx,
        output txByteReady,
        output tx
    );
endinterface

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: 8N1 frames (optionally 8E1), LSB first,
// with a start request that is active-low and sampled only in IDLE.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    uart_byte_tx_if.slave  io_txIf
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_baudCnt;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic             r_tx;
    logic             w_bitDone;

    assign w_bitDone           = (r_baudCnt == LAST_CNT);
    assign io_txIf.tx          = r_tx;
    assign io_txIf.txByteReady = (r_state == IDLE);

    // Frame sequencer; tx is loaded with the level of the state being entered
    // so the line is registered and changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_shift   <= 8'h00;
            r_parity  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (!io_txIf.txByteStart) begin
                        r_shift   <= io_txIf.byteForTx;
                        r_parity  <= ^io_txIf.byteForTx;
                        r_baudCnt <= '0;
                        r_bitIdx  <= '0;
                        r_tx      <= 1'b0;
                        r_state   <= START;
                    end
                end

                START: begin
                    if (w_bitDone) begin
                        r_baudCnt <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= DATA;
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end

                DATA: begin
                    if (w_bitDone) begin
                        r_baudCnt <= '0;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        if (r_bitIdx == 3'd7) begin
                            r_bitIdx <= '0;
                            if (PARITY_EN) begin
                                r_tx    <= r_parity;
                                r_state <= PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                            r_tx     <= r_shift[1];
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (w_bitDone) begin
                        r_baudCnt <= '0;
                        r_tx      <= 1'b1;
                        r_state   <= STOP;
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end

                STOP: begin
                    if (w_bitDone) begin
                        r_baudCnt <= '0;
                        r_tx      <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end

                default: begin
                    r_baudCnt <= '0;
                    r_bitIdx  <= '0;
                    r_tx      <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Testbench for uart_byte_tx: four instances (4/no parity, 4/parity,
// 2/no parity, 434/no parity) decoded by a cycle-accurate frame receiver.
module tb_uart_byte_tx;

    localparam int CPB_TAB [4] = '{4, 4, 2, 434};

    logic       clk;
    logic       rst;
    logic [3:0] startN;
    logic [7:0] txByte;
    logic [1:0] sel;
    logic [3:0] txLines;
    logic [3:0] readyLines;
    logic       selTx;
    logic       selReady;

    int compareCount;
    int mismatchCount;
    logic [7:0] expQ [$];

    uart_byte_tx_if if0 ();
    uart_byte_tx_if if1 ();
    uart_byte_tx_if if2 ();
    uart_byte_tx_if if3 ();

    assign if0.txByteStart = startN[0];
    assign if1.txByteStart = startN[1];
    assign if2.txByteStart = startN[2];
    assign if3.txByteStart = startN[3];
    assign if0.byteForTx   = txByte;
    assign if1.byteForTx   = txByte;
    assign if2.byteForTx   = txByte;
    assign if3.byteForTx   = txByte;

    uart_byte_tx #(.CLKS_PER_BIT(4),   .PARITY_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .io_txIf(if0));
    uart_byte_tx #(.CLKS_PER_BIT(4),   .PARITY_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .io_txIf(if1));
    uart_byte_tx #(.CLKS_PER_BIT(2),   .PARITY_EN(1'b0)) dut2 (.clk(clk), .rst(rst), .io_txIf(if2));
    uart_byte_tx #(.CLKS_PER_BIT(434), .PARITY_EN(1'b0)) dut3 (.clk(clk), .rst(rst), .io_txIf(if3));

    assign txLines    = {if3.tx, if2.tx, if1.tx, if0.tx};
    assign readyLines = {if3.txByteReady, if2.txByteReady, if1.txByteReady, if0.txByteReady};

    // Route the instance under test to the receiver.
    always_comb begin
        selTx    = txLines[sel];
        selReady = readyLines[sel];
    end

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Request one byte on the selected instance; called just after a negedge.
    task automatic applyStimulus(input logic [7:0] b, input bit push);
        txByte      = b;
        startN[sel] = 1'b0;
        if (push) expQ.push_back(b);
        @(negedge clk);
        startN[sel] = 1'b1;
    endtask

    // Receive one frame, checking every cycle of every bit, then compare
    // against the oldest expected byte.
    task automatic rxFrame(input int limit, output int waited);
        int         cpb;
        bit         par;
        int         nbits;
        logic [10:0] lvl;
        bit         stable;
        bit         readyLow;
        logic [7:0] got;
        logic [7:0] exp;
        cpb    = CPB_TAB[sel];
        par    = (sel == 2'd1);
        nbits  = par ? 11 : 10;
        waited = 0;
        while (selTx !== 1'b0 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        if (selTx !== 1'b0) begin
            checkOutput("rxTimeout", 32'd0, 32'd1);
            if (expQ.size() > 0) void'(expQ.pop_front());
            return;
        end
        stable   = 1'b1;
        readyLow = 1'b1;
        lvl      = '1;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < cpb; c++) begin
                if (c == 0) lvl[b] = selTx;
                else if (selTx !== lvl[b]) stable = 1'b0;
                if (selReady !== 1'b0) readyLow = 1'b0;
                @(negedge clk);
            end
        end
        got = lvl[8:1];
        if (expQ.size() == 0) begin
            checkOutput("sbEmpty", 32'd1, 32'd0);
            return;
        end
        exp = expQ.pop_front();
        checkOutput("startBit", 32'(lvl[0]), 32'd0);
        checkOutput("rxByte", 32'(got), 32'(exp));
        if (par) checkOutput("parityBit", 32'(lvl[9]), 32'(^exp));
        checkOutput("stopBit", 32'(lvl[nbits-1]), 32'd1);
        checkOutput("bitStable", 32'(stable), 32'd1);
        checkOutput("busyReadyLow", 32'(readyLow), 32'd1);
        checkOutput("readyBack", 32'(selReady), 32'd1);
        checkOutput("idleTx", 32'(selTx), 32'd1);
    endtask

    // Send one byte on the selected instance and receive it.
    task automatic oneFrame(input logic [7:0] b);
        int w;
        fork
            rxFrame(20, w);
            applyStimulus(b, 1'b1);
        join
    endtask

    initial begin
        int w1;
        int w2;
        int n;
        bit bad;
        compareCount  = 0;
        mismatchCount = 0;
        sel    = 2'd0;
        txByte = 8'hA5;
        startN = 4'b0000;
        rst    = 1'b1;

        // Reset with start requests held low: they must be ignored.
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        startN = 4'b1111;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #0;
            checkOutput("rstReady", 32'(selReady), 32'd1);
            checkOutput("rstTx", 32'(selTx), 32'd1);
        end

        $display("[TB] basic and random frames");
        sel = 2'd0;
        oneFrame(8'hA5);
        oneFrame(8'h01);
        oneFrame(8'h80);
        for (int i = 0; i < 3; i++) oneFrame(8'($urandom_range(0, 255)));

        $display("[TB] parity frames");
        sel = 2'd1;
        oneFrame(8'h07);
        oneFrame(8'h03);
        oneFrame(8'h5A);

        $display("[TB] busy ignore");
        sel = 2'd0;
        fork
            rxFrame(20, w1);
            begin
                applyStimulus(8'h55, 1'b1);
                repeat (9) @(negedge clk);
                txByte    = 8'hFF;
                startN[0] = 1'b0;
                @(negedge clk);
                startN[0] = 1'b1;
                for (int i = 0; i < 20; i++) begin
                    txByte = 8'($urandom_range(0, 255));
                    @(negedge clk);
                end
            end
        join
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (selTx !== 1'b1 || selReady !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        checkOutput("noSecondFrame", 32'(bad), 32'd0);

        $display("[TB] back-to-back");
        fork
            begin
                rxFrame(20, w1);
                rxFrame(20, w2);
                checkOutput("b2bGap", 32'(w2), 32'd1);
            end
            begin
                txByte    = 8'h00;
                startN[0] = 1'b0;
                expQ.push_back(8'h00);
                @(negedge clk);
                txByte = 8'hFF;
                expQ.push_back(8'hFF);
                n = 0;
                while (selReady !== 1'b1 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                checkOutput("b2bReadyWait", 32'(n), 32'd40);
                @(negedge clk);
                startN[0] = 1'b1;
            end
        join
        repeat (5) @(negedge clk);

        $display("[TB] mid-frame reset");
        applyStimulus(8'h00, 1'b0);
        repeat (16) @(negedge clk);
        checkOutput("preResetTx", 32'(selTx), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortTx", 32'(selTx), 32'd1);
        checkOutput("abortReady", 32'(selReady), 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (selTx !== 1'b1 || selReady !== 1'b1) bad = 1'b1;
        end
        checkOutput("noResume", 32'(bad), 32'd0);
        oneFrame(8'h00);

        $display("[TB] divisor sweep");
        sel = 2'd2;
        oneFrame(8'h3C);
        sel = 2'd3;
        oneFrame(8'h3C);

        checkOutput("sbDrained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
